// File: rtl/qlearn_pkg.sv
// Shared types and constants for the 6x6 maze Q-learning engine.
package qlearn_pkg;

    localparam int GRID_W    = 6;
    localparam int N_STATES  = 36;
    localparam int N_BLOCKED = 16;

    typedef logic [5:0] state_t;

    typedef enum logic [1:0] {
        ACT_N = 2'd0,
        ACT_E = 2'd1,
        ACT_S = 2'd2,
        ACT_W = 2'd3
    } action_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_RD_CUR,
        ST_CHOOSE,
        ST_RD_NXT,
        ST_UPDATE,
        ST_WRITE,
        ST_EP_END,
        ST_DONE
    } fsm_t;

endpackage

// File: rtl/qlearn_next_state.sv
// Resolves one move on the grid; walls and blocked states leave the agent in place.
module qlearn_next_state
    import qlearn_pkg::*;
(
    input  logic [5:0]  cur,
    input  logic [1:0]  action,
    input  logic [95:0] blocked,
    output logic [5:0]  nxt,
    output logic        bump
);

    state_t cand;
    state_t col;
    logic   legal;
    logic   hit;

    always_comb begin
        col   = (cur - 6'd1) % 6'(GRID_W);
        cand  = cur;
        legal = 1'b0;
        unique case (action_t'(action))
            ACT_N: begin cand = cur + 6'(GRID_W); legal = (cur <= 6'(N_STATES - GRID_W)); end
            ACT_E: begin cand = cur + 6'd1;       legal = (col != 6'(GRID_W - 1));        end
            ACT_S: begin cand = cur - 6'(GRID_W); legal = (cur >= 6'(GRID_W + 1));        end
            ACT_W: begin cand = cur - 6'd1;       legal = (col != 6'd0);                  end
        endcase
        // entry 0 of the blocked list is reserved and never compared
        hit = 1'b0;
        for (int unsigned i = 1; i < N_BLOCKED; i++) begin
            if (blocked[6*i +: 6] == cand) hit = 1'b1;
        end
        bump = !legal || hit;
        nxt  = bump ? cur : cand;
    end

endmodule

// File: rtl/qlearn_sequencer.sv
// Episode/step controller: sequences Q-row reads, epsilon-greedy choice and Bellman writes.
module qlearn_sequencer
    import qlearn_pkg::*;
#(
    parameter int          Q_W         = 32,
    parameter int          MAX_STEPS   = 64,
    parameter int          R_GOAL      = 1000,
    parameter int          ALPHA_SHIFT = 2,
    parameter int          GAMMA_SHIFT = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       start_state,
    input  logic [5:0]       target_state,
    input  logic [95:0]      blocked,
    input  logic [15:0]      num_episodes,
    input  logic [7:0]       epsilon,
    output logic             q_rd_en,
    output logic [5:0]       q_rd_state,
    input  logic [4*Q_W-1:0] q_rd_data,
    output logic             q_wr_en,
    output logic [5:0]       q_wr_state,
    output logic [1:0]       q_wr_action,
    output logic [Q_W-1:0]   q_wr_data,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [5:0]       cur_state,
    output logic [15:0]      episode_cnt,
    output logic [6:0]       step_cnt
);

    localparam int DW = Q_W + 2;

    fsm_t           st;
    logic [15:0]    lfsr;
    logic [1:0]     act_r;
    logic [Q_W-1:0] q_cur;
    state_t         nxt_r;
    logic           bump_r;

    logic [1:0]     best_i;
    logic [Q_W-1:0] best_v;
    logic [1:0]     act_sel;
    state_t         nxt_c;
    logic           bump_c;
    logic           start_blk;
    logic           bad_cfg;
    logic [DW-1:0]  rew;
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] upd;
    logic [Q_W-1:0] new_val;

    qlearn_next_state u_next (
        .cur     (cur_state),
        .action  (act_sel),
        .blocked (blocked),
        .nxt     (nxt_c),
        .bump    (bump_c)
    );

    // One argmax serves both reads: action choice on the current row, max on the next row.
    always_comb begin
        best_i = 2'd0;
        best_v = q_rd_data[0 +: Q_W];
        for (int unsigned i = 1; i < 4; i++) begin
            if (q_rd_data[i*Q_W +: Q_W] > best_v) begin
                best_v = q_rd_data[i*Q_W +: Q_W];
                best_i = 2'(i);
            end
        end
        act_sel = (lfsr[7:0] < epsilon) ? lfsr[9:8] : best_i;
    end

    always_comb begin
        start_blk = 1'b0;
        for (int unsigned i = 1; i < N_BLOCKED; i++) begin
            if (blocked[6*i +: 6] == start_state) start_blk = 1'b1;
        end
        bad_cfg = (start_state == target_state) || start_blk ||
                  (start_state == 6'd0) || (start_state > 6'(N_STATES));
    end

    always_comb begin
        rew = (!bump_r && nxt_r == target_state) ? DW'(R_GOAL) : '0;
        d   = $signed(rew + {2'b00, best_v} - {2'b00, best_v >> GAMMA_SHIFT} - {2'b00, q_cur});
        upd = $signed({2'b00, q_cur}) + (d >>> ALPHA_SHIFT);
        if (upd[DW-1])      new_val = '0;
        else if (upd[DW-2]) new_val = '1;
        else                new_val = upd[Q_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= ST_IDLE;
            lfsr        <= LFSR_SEED;
            act_r       <= '0;
            q_cur       <= '0;
            nxt_r       <= '0;
            bump_r      <= 1'b0;
            q_rd_en     <= 1'b0;
            q_rd_state  <= '0;
            q_wr_en     <= 1'b0;
            q_wr_state  <= '0;
            q_wr_action <= '0;
            q_wr_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            cur_state   <= '0;
            episode_cnt <= '0;
            step_cnt    <= '0;
        end else begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            q_rd_en <= 1'b0;
            q_wr_en <= 1'b0;
            unique case (st)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        st          <= ST_INIT;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        cfg_err     <= 1'b0;
                        episode_cnt <= '0;
                    end
                end
                ST_INIT: begin
                    if (bad_cfg || num_episodes == 16'd0) begin
                        cfg_err <= bad_cfg;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        st      <= ST_DONE;
                    end else begin
                        cur_state  <= start_state;
                        step_cnt   <= '0;
                        q_rd_en    <= 1'b1;
                        q_rd_state <= start_state;
                        st         <= ST_RD_CUR;
                    end
                end
                ST_RD_CUR: st <= ST_CHOOSE;
                ST_CHOOSE: begin
                    act_r      <= act_sel;
                    q_cur      <= q_rd_data[act_sel*Q_W +: Q_W];
                    nxt_r      <= nxt_c;
                    bump_r     <= bump_c;
                    q_rd_en    <= 1'b1;
                    q_rd_state <= nxt_c;
                    st         <= ST_RD_NXT;
                end
                ST_RD_NXT: st <= ST_UPDATE;
                ST_UPDATE: begin
                    q_wr_en     <= 1'b1;
                    q_wr_state  <= cur_state;
                    q_wr_action <= act_r;
                    q_wr_data   <= new_val;
                    st          <= ST_WRITE;
                end
                ST_WRITE: begin
                    step_cnt <= step_cnt + 7'd1;
                    if (nxt_r == target_state || (step_cnt + 7'd1) >= 7'(MAX_STEPS)) begin
                        st <= ST_EP_END;
                    end else begin
                        cur_state  <= nxt_r;
                        q_rd_en    <= 1'b1;
                        q_rd_state <= nxt_r;
                        st         <= ST_RD_CUR;
                    end
                end
                ST_EP_END: begin
                    episode_cnt <= episode_cnt + 16'd1;
                    if (episode_cnt + 16'd1 == num_episodes) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        st   <= ST_DONE;
                    end else begin
                        cur_state  <= start_state;
                        step_cnt   <= '0;
                        q_rd_en    <= 1'b1;
                        q_rd_state <= start_state;
                        st         <= ST_RD_CUR;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
